// File: rtl/bp_stream_mmio_responder.sv
// Memory-side endpoint for uncached I/O commands targeting the host.
// Each command becomes one NBF packet {opcode, addr, data} sent LSB flit first;
// reads then gather a return dword from the inbound stream before responding.
// The processor configuration is flattened into explicit width parameters.
module bp_stream_mmio_responder #(
  parameter int unsigned paddr_width_p       = 40,
  parameter int unsigned cce_block_width_p   = 512,
  parameter int unsigned payload_width_p     = 16,
  parameter int unsigned stream_data_width_p = 32,
  parameter int unsigned nbf_opcode_width_p  = 8,
  parameter int unsigned nbf_addr_width_p    = paddr_width_p,
  parameter int unsigned nbf_data_width_p    = 64,
  localparam int unsigned cce_mem_header_width_lp = payload_width_p + 3 + paddr_width_p + 4,
  localparam int unsigned cce_mem_msg_width_lp    = cce_mem_header_width_lp + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,

  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,

  output logic [stream_data_width_p-1:0]  stream_data_o,
  output logic                            stream_v_o,
  input  logic                            stream_yumi_i,

  input  logic [stream_data_width_p-1:0]  stream_data_i,
  input  logic                            stream_v_i,
  output logic                            stream_ready_o,

  output logic                            idle_o
);

  localparam int unsigned nbf_width_lp      = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int unsigned nbf_num_flits_lp  = (nbf_width_lp + stream_data_width_p - 1) / stream_data_width_p;
  localparam int unsigned rd_num_flits_lp   = (nbf_data_width_p + stream_data_width_p - 1) / stream_data_width_p;
  localparam int unsigned pkt_width_lp      = nbf_num_flits_lp * stream_data_width_p;
  localparam int unsigned rd_width_lp       = rd_num_flits_lp * stream_data_width_p;
  localparam int unsigned flit_cnt_width_lp = (nbf_num_flits_lp > 1) ? $clog2(nbf_num_flits_lp) : 1;
  localparam int unsigned rd_cnt_width_lp   = (rd_num_flits_lp > 1) ? $clog2(rd_num_flits_lp) : 1;

  localparam logic [3:0] mem_uc_wr_lp = 4'd3;

  // BedRock memory header, msg_type in the LSBs
  typedef struct packed {
    logic [payload_width_p-1:0] payload;
    logic [2:0]                 size;
    logic [paddr_width_p-1:0]   addr;
    logic [3:0]                 msg_type;
  } mem_header_s;

  typedef enum logic [1:0] {e_ready, e_send, e_wait_rd, e_resp} state_e;

  state_e                                              state_r;
  mem_header_s                                         hdr_r;
  logic                                                is_wr_r;
  logic [nbf_num_flits_lp-1:0][stream_data_width_p-1:0] pkt_r;
  logic [rd_num_flits_lp-1:0][stream_data_width_p-1:0]  rd_data_r;
  logic [flit_cnt_width_lp-1:0]                        flit_cnt_r;
  logic [flit_cnt_width_lp-1:0]                        flit_cnt_n;
  logic [rd_cnt_width_lp-1:0]                          rd_cnt_r;
  logic [stream_data_width_p-1:0]                      stream_data_r;
  logic                                                cmd_ready_r;
  logic                                                resp_v_r;
  logic                                                stream_v_r;
  logic                                                stream_ready_r;
  logic                                                idle_r;

  mem_header_s                    hdr_c;
  logic                           cmd_is_wr_c;
  logic [1:0]                     size_code_c;
  logic [nbf_opcode_width_p-1:0]  opcode_c;
  logic [nbf_data_width_p-1:0]    data_c;
  logic [pkt_width_lp-1:0]        pkt_c;
  logic [rd_width_lp-1:0]         rd_flat;
  logic                           unused_cmd_data;

  // Decode the incoming command into its NBF packet
  always_comb begin
    hdr_c       = mem_header_s'(io_cmd_i[cce_mem_header_width_lp-1:0]);
    cmd_is_wr_c = (hdr_c.msg_type == mem_uc_wr_lp);
    size_code_c = (hdr_c.size > 3'd3) ? 2'd3 : hdr_c.size[1:0];
    opcode_c    = '0;
    opcode_c[4] = ~cmd_is_wr_c;
    opcode_c[1:0] = size_code_c;
    data_c      = cmd_is_wr_c ? io_cmd_i[cce_mem_header_width_lp +: nbf_data_width_p] : '0;
    pkt_c       = pkt_width_lp'({opcode_c, nbf_addr_width_p'(hdr_c.addr), data_c});
  end

  // Block data beyond the dword is intentionally dropped
  assign unused_cmd_data = ^io_cmd_i[cce_mem_msg_width_lp-1:cce_mem_header_width_lp+nbf_data_width_p];

  assign flit_cnt_n = flit_cnt_r + flit_cnt_width_lp'(1);

  // Command/packet/response sequencer with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r        <= e_ready;
      hdr_r          <= '0;
      is_wr_r        <= 1'b0;
      pkt_r          <= '0;
      rd_data_r      <= '0;
      flit_cnt_r     <= '0;
      rd_cnt_r       <= '0;
      stream_data_r  <= '0;
      cmd_ready_r    <= 1'b0;
      resp_v_r       <= 1'b0;
      stream_v_r     <= 1'b0;
      stream_ready_r <= 1'b0;
      idle_r         <= 1'b1;
    end else begin
      case (state_r)
        e_ready: begin
          cmd_ready_r <= 1'b1;
          idle_r      <= 1'b1;
          if (io_cmd_v_i && cmd_ready_r) begin
            hdr_r         <= hdr_c;
            is_wr_r       <= cmd_is_wr_c;
            pkt_r         <= pkt_c;
            rd_data_r     <= '0;
            flit_cnt_r    <= '0;
            rd_cnt_r      <= '0;
            stream_data_r <= pkt_c[stream_data_width_p-1:0];
            stream_v_r    <= 1'b1;
            cmd_ready_r   <= 1'b0;
            idle_r        <= 1'b0;
            state_r       <= e_send;
          end
        end
        e_send: begin
          if (stream_yumi_i && stream_v_r) begin
            if (flit_cnt_r == flit_cnt_width_lp'(nbf_num_flits_lp - 1)) begin
              stream_v_r <= 1'b0;
              if (is_wr_r) begin
                resp_v_r <= 1'b1;
                state_r  <= e_resp;
              end else begin
                stream_ready_r <= 1'b1;
                rd_cnt_r       <= '0;
                state_r        <= e_wait_rd;
              end
            end else begin
              flit_cnt_r    <= flit_cnt_n;
              stream_data_r <= pkt_r[flit_cnt_n];
            end
          end
        end
        e_wait_rd: begin
          if (stream_v_i && stream_ready_r) begin
            rd_data_r[rd_cnt_r] <= stream_data_i;
            if (rd_cnt_r == rd_cnt_width_lp'(rd_num_flits_lp - 1)) begin
              stream_ready_r <= 1'b0;
              resp_v_r       <= 1'b1;
              state_r        <= e_resp;
            end else begin
              rd_cnt_r <= rd_cnt_r + rd_cnt_width_lp'(1);
            end
          end
        end
        e_resp: begin
          if (io_resp_yumi_i && resp_v_r) begin
            resp_v_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            idle_r      <= 1'b1;
            state_r     <= e_ready;
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  // Read data is cleared on accept, so writes naturally return zero
  assign rd_flat        = rd_data_r;
  assign io_resp_o      = {cce_block_width_p'(rd_flat[nbf_data_width_p-1:0]), hdr_r};
  assign io_resp_v_o    = resp_v_r;
  assign io_cmd_ready_o = cmd_ready_r;
  assign stream_data_o  = stream_data_r;
  assign stream_v_o     = stream_v_r;
  assign stream_ready_o = stream_ready_r;
  assign idle_o         = idle_r;

endmodule

// File: tb/tb_bp_stream_mmio_responder.sv
// Directed bench for bp_stream_mmio_responder with hand-computed flits and responses.
module tb_bp_stream_mmio_responder;

  localparam int unsigned HDR_W = 63;
  localparam int unsigned MSG_W = HDR_W + 512;
  localparam logic [3:0] UC_RD = 4'd2;
  localparam logic [3:0] UC_WR = 4'd3;

  logic             clk;
  logic             reset_n_i;
  logic [MSG_W-1:0] io_cmd_i;
  logic             io_cmd_v_i;
  logic             io_cmd_ready_o;
  logic [MSG_W-1:0] io_resp_o;
  logic             io_resp_v_o;
  logic             io_resp_yumi_i;
  logic [31:0]      stream_data_o;
  logic             stream_v_o;
  logic             stream_yumi_i;
  logic [31:0]      stream_data_i;
  logic             stream_v_i;
  logic             stream_ready_o;
  logic             idle_o;

  int checks = 0;
  int errors = 0;

  bp_stream_mmio_responder dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .io_cmd_i       (io_cmd_i),
    .io_cmd_v_i     (io_cmd_v_i),
    .io_cmd_ready_o (io_cmd_ready_o),
    .io_resp_o      (io_resp_o),
    .io_resp_v_o    (io_resp_v_o),
    .io_resp_yumi_i (io_resp_yumi_i),
    .stream_data_o  (stream_data_o),
    .stream_v_o     (stream_v_o),
    .stream_yumi_i  (stream_yumi_i),
    .stream_data_i  (stream_data_i),
    .stream_v_i     (stream_v_i),
    .stream_ready_o (stream_ready_o),
    .idle_o         (idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HDR_W-1:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                              input logic [39:0] a, input logic [15:0] p);
    return {p, s, a, t};
  endfunction

  function automatic logic [MSG_W-1:0] mk_msg(input logic [HDR_W-1:0] h, input logic [63:0] d);
    logic [MSG_W-1:0] m;
    m = '0;
    m[HDR_W-1:0]     = h;
    m[HDR_W +: 64]   = d;
    m[MSG_W-1 -: 8]  = 8'hA5;
    return m;
  endfunction

  task automatic send_cmd(input logic [MSG_W-1:0] m);
    int n;
    n = 0;
    while (!io_cmd_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready", 128'(io_cmd_ready_o), 128'(1));
    io_cmd_i   = m;
    io_cmd_v_i = 1'b1;
    tick();
    io_cmd_v_i = 1'b0;
    io_cmd_i   = '0;
  endtask

  task automatic run_flits(input logic [3:0][31:0] f);
    for (int i = 0; i < 4; i++) begin
      chk("flit_v", 128'(stream_v_o), 128'(1));
      chk("flit_data", 128'(stream_data_o), 128'(f[i]));
      chk("flit_rdy_off", 128'(stream_ready_o), 128'(0));
      stream_yumi_i = 1'b1;
      tick();
    end
    stream_yumi_i = 1'b0;
  endtask

  task automatic chk_resp(input logic [HDR_W-1:0] h, input logic [63:0] d);
    chk("resp_v", 128'(io_resp_v_o), 128'(1));
    chk("resp_hdr", 128'(io_resp_o[HDR_W-1:0]), 128'(h));
    chk("resp_data", 128'(io_resp_o[HDR_W +: 64]), 128'(d));
    chk("resp_hi_zero", 128'(|io_resp_o[MSG_W-1:HDR_W+64]), 128'(0));
    chk("resp_cmd_rdy", 128'(io_cmd_ready_o), 128'(0));
  endtask

  task automatic take_resp();
    io_resp_yumi_i = 1'b1;
    tick();
    io_resp_yumi_i = 1'b0;
    chk("post_yumi_v", 128'(io_resp_v_o), 128'(0));
    chk("post_yumi_rdy", 128'(io_cmd_ready_o), 128'(1));
    chk("post_yumi_idle", 128'(idle_o), 128'(1));
  endtask

  logic [HDR_W-1:0] h;
  int k;
  int c;

  initial begin
    reset_n_i      = 1'b0;
    io_cmd_i       = '0;
    io_cmd_v_i     = 1'b0;
    io_resp_yumi_i = 1'b0;
    stream_yumi_i  = 1'b0;
    stream_data_i  = '0;
    stream_v_i     = 1'b0;
    tick();
    tick();
    chk("rst_cmd_rdy", 128'(io_cmd_ready_o), 128'(0));
    chk("rst_resp_v", 128'(io_resp_v_o), 128'(0));
    chk("rst_stream_v", 128'(stream_v_o), 128'(0));
    chk("rst_stream_rdy", 128'(stream_ready_o), 128'(0));
    chk("rst_idle", 128'(idle_o), 128'(1));
    reset_n_i = 1'b1;

    // 1: 8B write, back-to-back flits
    h = mk_hdr(UC_WR, 3'd3, 40'h00_8000_1000, 16'h0001);
    send_cmd(mk_msg(h, 64'h1122_3344_5566_7788));
    chk("t1_busy", 128'(idle_o), 128'(0));
    run_flits({32'h0000_0300, 32'h8000_1000, 32'h1122_3344, 32'h5566_7788});
    chk_resp(h, 64'h0);
    take_resp();

    // 2: 4B read with data returned over two flits
    h = mk_hdr(UC_RD, 3'd2, 40'h00_0010_0000, 16'h5A5A);
    send_cmd(mk_msg(h, 64'hFFFF_FFFF_FFFF_FFFF));
    run_flits({32'h0000_1200, 32'h0010_0000, 32'h0000_0000, 32'h0000_0000});
    chk("t2_rdy", 128'(stream_ready_o), 128'(1));
    chk("t2_no_resp", 128'(io_resp_v_o), 128'(0));
    stream_v_i    = 1'b1;
    stream_data_i = 32'hDEAD_BEEF;
    tick();
    stream_data_i = 32'h0000_0000;
    tick();
    stream_v_i = 1'b0;
    chk("t2_rdy_off", 128'(stream_ready_o), 128'(0));
    chk_resp(h, 64'h0000_0000_DEAD_BEEF);
    take_resp();

    // 3: write with alternating yumi; flits hold until consumed
    h = mk_hdr(UC_WR, 3'd2, 40'h12_3456_789A, 16'h0003);
    send_cmd(mk_msg(h, 64'hAAAA_5555_0F0F_0F0F));
    begin
      logic [3:0][31:0] f;
      f = {32'h0000_0212, 32'h3456_789A, 32'hAAAA_5555, 32'h0F0F_0F0F};
      k = 0;
      c = 0;
      while (!io_resp_v_o && c < 20 && k < 4) begin
        chk("t3_v", 128'(stream_v_o), 128'(1));
        chk("t3_flit", 128'(stream_data_o), 128'(f[k]));
        stream_yumi_i = (c % 2 == 0);
        tick();
        if (stream_yumi_i) k++;
        c++;
      end
      stream_yumi_i = 1'b0;
    end
    chk("t3_yumis", 128'(k), 128'(4));
    chk("t3_cycles", 128'(c), 128'(7));
    chk_resp(h, 64'h0);

    // 4: response stalls for 10 cycles
    for (int i = 0; i < 10; i++) begin
      chk("t4_v", 128'(io_resp_v_o), 128'(1));
      chk("t4_hdr", 128'(io_resp_o[HDR_W-1:0]), 128'(h));
      chk("t4_data", 128'(io_resp_o[HDR_W +: 64]), 128'(0));
      chk("t4_rdy", 128'(io_cmd_ready_o), 128'(0));
      tick();
    end
    take_resp();

    // 6: inbound junk ignored outside wait; non-uc_wr type and 32B size act as 8B read
    stream_v_i    = 1'b1;
    stream_data_i = 32'hCAFE_F00D;
    tick();
    chk("t6_rdy_idle", 128'(stream_ready_o), 128'(0));
    h = mk_hdr(4'd0, 3'd5, 40'h00_0000_0040, 16'h0006);
    send_cmd(mk_msg(h, 64'h1234_5678_9ABC_DEF0));
    run_flits({32'h0000_1300, 32'h0000_0040, 32'h0000_0000, 32'h0000_0000});
    stream_data_i = 32'h0123_4567;
    tick();
    stream_v_i = 1'b0;
    tick();
    chk("t6_rdy_wait", 128'(stream_ready_o), 128'(1));
    chk("t6_no_resp", 128'(io_resp_v_o), 128'(0));
    stream_v_i    = 1'b1;
    stream_data_i = 32'h89AB_CDEF;
    tick();
    stream_v_i    = 1'b0;
    stream_data_i = 32'hCAFE_F00D;
    chk_resp(h, 64'h89AB_CDEF_0123_4567);
    take_resp();

    // 5: reset while flit 2 is pending, then a fresh write
    h = mk_hdr(UC_WR, 3'd0, 40'h00_0000_0007, 16'h0005);
    send_cmd(mk_msg(h, 64'h0000_0000_0000_00EE));
    stream_yumi_i = 1'b1;
    tick();
    tick();
    stream_yumi_i = 1'b0;
    chk("t5_flit2", 128'(stream_data_o), 128'(32'h0000_0007));
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    chk("t5_stream_v", 128'(stream_v_o), 128'(0));
    chk("t5_resp_v", 128'(io_resp_v_o), 128'(0));
    chk("t5_stream_rdy", 128'(stream_ready_o), 128'(0));
    chk("t5_idle", 128'(idle_o), 128'(1));
    tick();
    tick();
    chk("t5_no_stale", 128'(io_resp_v_o), 128'(0));
    h = mk_hdr(UC_WR, 3'd1, 40'h00_0000_2000, 16'h0055);
    send_cmd(mk_msg(h, 64'h0000_0000_0000_BEEF));
    run_flits({32'h0000_0100, 32'h0000_2000, 32'h0000_0000, 32'h0000_BEEF});
    chk_resp(h, 64'h0);
    take_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
